// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared encodings for the activation vector unit
// Contents: activation mode encodings (as seen on the mode port) and the
// controller state enum used by act_vec_unit.
package act_pkg;

    localparam logic [1:0] MODE_RELU  = 2'b00;
    localparam logic [1:0] MODE_LEAKY = 2'b01;
    localparam logic [1:0] MODE_CLIP  = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PROCESS = 2'd1,
        ST_FINISH  = 2'd2
    } act_state_e;

endpackage

// File: rtl/act_lane.sv
// rtl/act_lane.sv - combinational single-element activation datapath
// Ports:
//   i_x       signed input element
//   i_mode    activation mode (act_pkg MODE_*)
//   i_clip    signed upper bound for clipped mode
//   i_shift   arithmetic right-shift amount for leaky mode
//   o_y       activated element
//   o_altered high when o_y differs from i_x
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT_W    = 8
) (
    input  logic signed [DATA_WIDTH-1:0] i_x,
    input  logic        [1:0]            i_mode,
    input  logic signed [DATA_WIDTH-1:0] i_clip,
    input  logic        [SHIFT_W-1:0]    i_shift,
    output logic signed [DATA_WIDTH-1:0] o_y,
    output logic                         o_altered
);

    logic w_x_neg;
    logic w_clip_neg;

    assign w_x_neg    = i_x[DATA_WIDTH-1];
    assign w_clip_neg = i_clip[DATA_WIDTH-1];

    always_comb begin
        o_y = i_x;
        case (i_mode)
            MODE_RELU: begin
                if (w_x_neg) o_y = '0;
            end
            MODE_LEAKY: begin
                // >>> on a signed operand rounds toward minus infinity
                if (w_x_neg) o_y = i_x >>> i_shift;
            end
            MODE_CLIP: begin
                // A negative bound leaves no legal non-negative value, so
                // everything collapses to zero.
                if (w_x_neg || w_clip_neg) o_y = '0;
                else if (i_x > i_clip)     o_y = i_clip;
            end
            MODE_PASS: begin
                o_y = i_x;
            end
            default: begin
                o_y = i_x;
            end
        endcase
    end

    assign o_altered = (o_y != i_x);

endmodule

// File: rtl/act_vec_unit.sv
// rtl/act_vec_unit.sv - multi-lane activation unit over a flattened vector
// Optional feature macro: ACT_SAT_COUNT_EN (adds sat_count output)
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   start           request to process one vector (accepted only in IDLE)
//   mode, clip_val  activation mode and clip bound, latched on accept
//   input_vector    flattened signed elements, sampled LANES per beat
//   output_vector   registered results, same packing
//   busy, done      processing flag, one-cycle completion pulse
//   sat_count       (ACT_SAT_COUNT_EN) elements altered in the last run
module act_vec_unit
    import act_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [DATA_WIDTH-1:0]         clip_val,
    input  logic [WIDTH*DATA_WIDTH-1:0]   input_vector,
    output logic [WIDTH*DATA_WIDTH-1:0]   output_vector,
    output logic                          busy,
`ifdef ACT_SAT_COUNT_EN
    output logic [$clog2(WIDTH+1)-1:0]    sat_count,
`endif
    output logic                          done
);

    localparam int BEATS   = WIDTH / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W   = $clog2(WIDTH * DATA_WIDTH);
    localparam int SHIFT_W = 8;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    act_state_e                r_state;
    logic [BEAT_W-1:0]         r_beat;
    logic [1:0]                r_mode;
    logic [DATA_WIDTH-1:0]     r_clip;
    logic [WIDTH*DATA_WIDTH-1:0] r_out;
    logic                      r_busy;
    logic                      r_done;

    logic [IDX_W-1:0]          w_base [LANES];
    logic [DATA_WIDTH-1:0]     w_y    [LANES];
    logic [LANES-1:0]          w_alt;
    logic                      w_accept;

    assign w_accept = (r_state == ST_IDLE) && start;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        // Bit offset of the element this lane handles in the current beat.
        assign w_base[g] = IDX_W'((int'(r_beat) * LANES + g) * DATA_WIDTH);

        act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_W    (SHIFT_W)
        ) u_lane (
            .i_x       (input_vector[w_base[g] +: DATA_WIDTH]),
            .i_mode    (r_mode),
            .i_clip    (r_clip),
            .i_shift   (SHIFT_W'(LEAK_SHIFT)),
            .o_y       (w_y[g]),
            .o_altered (w_alt[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_mode  <= MODE_RELU;
            r_clip  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_PROCESS;
                        r_beat  <= '0;
                        r_mode  <= mode;
                        r_clip  <= clip_val;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PROCESS: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_out[w_base[l] +: DATA_WIDTH] <= w_y[l];
                    end
                    if (r_beat == LAST_BEAT) begin
                        r_state <= ST_FINISH;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_vector = r_out;
    assign busy          = r_busy;
    assign done          = r_done;

`ifdef ACT_SAT_COUNT_EN
    logic [CNT_W-1:0] r_sat;
    logic [CNT_W-1:0] w_alt_cnt;

    always_comb begin
        w_alt_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            w_alt_cnt = w_alt_cnt + CNT_W'(w_alt[l]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat <= '0;
        end else if (w_accept) begin
            r_sat <= '0;
        end else if (r_state == ST_PROCESS) begin
            r_sat <= r_sat + w_alt_cnt;
        end
    end

    assign sat_count = r_sat;
`else
    logic w_unused_alt;
    assign w_unused_alt = ^w_alt;
`endif

endmodule

// File: tb/tb_act_vec_unit.sv
// tb/tb_act_vec_unit.sv - randomized self-checking bench for act_vec_unit
module tb_act_vec_unit;

    localparam int W     = 128;
    localparam int DW    = 16;
    localparam int LN    = 8;
    localparam int LS    = 3;
    localparam int BEATS = W / LN;

    logic               clk          = 1'b0;
    logic               reset_n      = 1'b0;
    logic               start        = 1'b0;
    logic [1:0]         mode         = 2'b00;
    logic [DW-1:0]      clip_val     = '0;
    logic [W*DW-1:0]    input_vector = '0;
    logic [W*DW-1:0]    output_vector;
    logic               busy;
    logic               done;
`ifdef ACT_SAT_COUNT_EN
    logic [$clog2(W+1)-1:0] sat_count;
`endif

    always #5 clk = ~clk;

    act_vec_unit #(
        .WIDTH      (W),
        .DATA_WIDTH (DW),
        .LANES      (LN),
        .LEAK_SHIFT (LS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .mode          (mode),
        .clip_val      (clip_val),
        .input_vector  (input_vector),
        .output_vector (output_vector),
        .busy          (busy),
`ifdef ACT_SAT_COUNT_EN
        .sat_count     (sat_count),
`endif
        .done          (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a run is "active" for phases 1..BEATS (one beat each)
    // and phase BEATS+1 (completion); the beat of phase p is p-1.
    bit         m_active = 1'b0;
    int         m_phase  = 0;
    logic [1:0] m_mode   = 2'b00;
    int         m_clip   = 0;
    int         m_out [W];
    int         m_sat    = 0;

    task automatic chk(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int act(input int x, input logic [1:0] md, input int c);
        int d;
        d = 1 << LS;
        case (md)
            2'b00:   return (x < 0) ? 0 : x;
            2'b01:   return (x < 0) ? -((-x + d - 1) / d) : x;
            2'b10:   return (x < 0 || c < 0) ? 0 : ((x > c) ? c : x);
            default: return x;
        endcase
    endfunction

    function automatic int in_elem(input int i);
        logic signed [DW-1:0] t;
        t = input_vector[i*DW +: DW];
        return int'(t);
    endfunction

    function automatic int out_elem(input int i);
        logic signed [DW-1:0] t;
        t = output_vector[i*DW +: DW];
        return int'(t);
    endfunction

    task automatic set_elem(input int i, input int v);
        logic [31:0] t;
        t = v;
        input_vector[i*DW +: DW] = t[DW-1:0];
    endtask

    task automatic rand_vec();
        for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 7))
                0:       set_elem(i, -32768);
                1:       set_elem(i, 32767);
                2:       set_elem(i, int'($urandom_range(0, 40)) - 20);
                default: set_elem(i, int'($urandom_range(0, 65535)) - 32768);
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Compare against the model, then advance it across the coming edge.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        int bad;
        if (!reset_n) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_mode   = 2'b00;
            m_clip   = 0;
            m_sat    = 0;
            for (int i = 0; i < W; i++) m_out[i] = 0;
        end
        exp_busy = m_active && (m_phase <= BEATS);
        exp_done = m_active && (m_phase == BEATS + 1);
        chk("busy", longint'(busy), longint'(exp_busy));
        chk("done", longint'(done), longint'(exp_done));
        bad = -1;
        for (int i = 0; i < W; i++) begin
            if (bad < 0 && out_elem(i) != m_out[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL out_elem[%0d] at cycle %0d: got %0d expected %0d",
                     bad, cyc, out_elem(bad), m_out[bad]);
        end
`ifdef ACT_SAT_COUNT_EN
        if (!exp_busy) chk("sat_count", longint'(sat_count), longint'(m_sat));
`endif
        if (reset_n) begin
            if (m_active) begin
                if (m_phase <= BEATS) begin
                    for (int l = 0; l < LN; l++) begin
                        int idx;
                        int x;
                        idx = (m_phase - 1) * LN + l;
                        x   = in_elem(idx);
                        m_out[idx] = act(x, m_mode, m_clip);
                        if (m_out[idx] != x) m_sat++;
                    end
                end
                if (m_phase == BEATS + 1) m_active = 1'b0;
                else m_phase++;
            end else if (start) begin
                logic signed [DW-1:0] cs;
                cs       = clip_val;
                m_active = 1'b1;
                m_phase  = 1;
                m_mode   = mode;
                m_clip   = int'(cs);
                m_sat    = 0;
            end
        end
    end

    task automatic run_vec(input logic [1:0] md, input logic [DW-1:0] cv,
                           input bit noise, output int lat);
        mode     = md;
        clip_val = cv;
        start    = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (noise) begin
                start    = ($urandom_range(0, 3) == 0);
                mode     = 2'($urandom_range(0, 3));
                clip_val = DW'($urandom);
            end
            step();
            lat++;
        end
        start = 1'b0;
        chk("run_done_seen", longint'(done === 1'b1), 1);
        step();
    endtask

    function automatic int count_nonzero();
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (out_elem(i) != 0) n++;
        return n;
    endfunction

    initial begin
        int lat;
        int dcyc [$];
        int guard;
        bit seen;

        // Pin the model with hand-computed values.
        chk("model_relu_m5",   act(-5, 2'b00, 0), 0);
        chk("model_leaky_m16", act(-16, 2'b01, 0), -2);
        chk("model_leaky_m1",  act(-1, 2'b01, 0), -1);
        chk("model_leaky_40",  act(40, 2'b01, 0), 40);
        chk("model_clip_150",  act(150, 2'b10, 100), 100);
        chk("model_clip_m1",   act(77, 2'b10, -1), 0);

        step(); step(); step();
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_out_nonzero", count_nonzero(), 0);
        reset_n = 1'b1;
        step();

        // ReLU on all -5, done latency 17.
        for (int i = 0; i < W; i++) set_elem(i, -5);
        run_vec(2'b00, '0, 1'b0, lat);
        chk("relu_latency", lat, 17);
        chk("relu_neg5_nonzero", count_nonzero(), 0);

        // Leaky.
        rand_vec();
        set_elem(0, -16); set_elem(1, -1); set_elem(2, 40);
        run_vec(2'b01, '0, 1'b0, lat);
        chk("leaky_e0", out_elem(0), -2);
        chk("leaky_e1", out_elem(1), -1);
        chk("leaky_e2", out_elem(2), 40);

        // Clipped at 100, then at -1.
        rand_vec();
        set_elem(0, 150); set_elem(1, 100); set_elem(2, 50); set_elem(3, -7);
        run_vec(2'b10, 16'd100, 1'b0, lat);
        chk("clip_e0", out_elem(0), 100);
        chk("clip_e1", out_elem(1), 100);
        chk("clip_e2", out_elem(2), 50);
        chk("clip_e3", out_elem(3), 0);
        rand_vec();
        run_vec(2'b10, 16'hFFFF, 1'b0, lat);
        chk("clip_neg_nonzero", count_nonzero(), 0);

        // start held high: back-to-back runs 18 cycles apart.
        rand_vec();
        mode  = 2'b11;
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (done === 1'b1) dcyc.push_back(cyc);
        end
        start = 1'b0;
        chk("held_done_count_ge3", longint'(dcyc.size() >= 3), 1);
        if (dcyc.size() >= 3) begin
            chk("held_gap1", dcyc[1] - dcyc[0], 18);
            chk("held_gap2", dcyc[2] - dcyc[1], 18);
        end
        guard = 0;
        while ((busy === 1'b1 || done === 1'b1) && guard < 40) begin
            step();
            guard++;
        end
        chk("held_drain", longint'(guard < 40), 1);

        // Randomized runs with stray start pulses and input noise mid-run.
        for (int r = 0; r < 30; r++) begin
            logic [DW-1:0] cv;
            rand_vec();
            cv = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 300));
            run_vec(2'($urandom_range(0, 3)), cv, 1'b1, lat);
            chk("rand_latency", lat, 17);
            repeat ($urandom_range(0, 2)) step();
        end

`ifdef ACT_SAT_COUNT_EN
        for (int i = 0; i < W; i++) begin
            if (i < 37) set_elem(i, -int'($urandom_range(1, 32768)));
            else set_elem(i, int'($urandom_range(0, 32767)));
        end
        run_vec(2'b00, '0, 1'b0, lat);
        chk("sat_count_37", longint'(sat_count), 37);
`endif

        // Reset mid-run at beat 3.
        rand_vec();
        run_vec(2'b11, '0, 1'b0, lat);
        mode  = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        reset_n = 1'b0;
        #1;
        chk("midreset_out_nonzero", count_nonzero(), 0);
        chk("midreset_busy", longint'(busy), 0);
        chk("midreset_done", longint'(done), 0);
        step(); step();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("midreset_no_done", longint'(seen), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/act_vec_unit.md
ACT_VEC_UNIT -- requirements
Module: act_vec_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 128, meaning elements per vector.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, meaning signed two's-complement element width.
REQ-003 The module SHALL have parameter LANES, default 8, meaning elements processed per cycle; WIDTH SHALL be a multiple of LANES.
REQ-004 The module SHALL have parameter LEAK_SHIFT, default 3, meaning the leaky-mode arithmetic right-shift amount.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port start, input, 1 bit: request to process one vector.
REQ-008 The module SHALL have port mode, input, 2 bits: 00 ReLU, 01 leaky ReLU, 10 clipped ReLU, 11 pass-through.
REQ-009 The module SHALL have port clip_val, input, DATA_WIDTH bits: upper bound for clipped mode, treated as signed.
REQ-010 The module SHALL have port input_vector, input, WIDTH*DATA_WIDTH bits: flattened vector, element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The module SHALL have port output_vector, output, WIDTH*DATA_WIDTH bits: registered results, same packing.
REQ-012 The module SHALL have port busy, output, 1 bit: high while a vector is being processed.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, PROCESS and FINISH.
REQ-015 In IDLE, start=1 SHALL latch mode and clip_val, clear the beat counter, and enter PROCESS; busy SHALL be high from the next cycle.
REQ-016 Each PROCESS cycle SHALL write LANES consecutive elements (beat b covers elements b*LANES to b*LANES+LANES-1) and then increment the beat.
REQ-017 After beat WIDTH/LANES-1 the FSM SHALL enter FINISH; FINISH SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-018 Latency from the start cycle to done SHALL be WIDTH/LANES+1 cycles.
REQ-019 start while busy SHALL be ignored; start in the FINISH cycle SHALL be ignored; start in IDLE the cycle after done SHALL be accepted.
REQ-020 input_vector SHALL be sampled per beat; the caller holds it stable while busy.
REQ-021 ReLU: x<0 gives 0, otherwise x.
REQ-022 Leaky: x<0 gives x>>>LEAK_SHIFT (arithmetic, floor), otherwise x.
REQ-023 Clipped: x<0 gives 0; x>clip_val gives clip_val; otherwise x; a negative latched clip_val SHALL yield 0 for every element.
REQ-024 Pass-through SHALL copy x unchanged.
REQ-025 Output elements not yet written in the current run SHALL keep their previous values.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, beat counter 0, busy 0, done 0, output_vector all zeros, latched mode 00 and latched clip 0, including mid-run; no done SHALL follow.

Configuration
REQ-027 With ACT_SAT_COUNT_EN defined, the module SHALL add an output sat_count of $clog2(WIDTH+1) bits that counts elements per run altered by the activation (zeroed, scaled or clipped); the count SHALL clear on accepted start, be valid with done, and hold until the next start.
REQ-028 Without ACT_SAT_COUNT_EN, the sat_count port and its logic SHALL be absent.

Structure
REQ-029 Package act_pkg SHALL hold the mode encodings and the FSM state enum.
REQ-030 The per-element datapath SHALL be the sub-module act_lane, which is combinational, takes x, mode, clip and shift, produces y and an altered flag, and is instantiated LANES times.

Verification
REQ-031 Reset mid-run: assert reset_n=0 at beat 3 -> outputs are 0, busy=0, and no done pulse follows.
REQ-032 ReLU, all elements = -5 (0xFFFB) -> all outputs 0; done appears exactly 17 cycles after start with the default parameters.
REQ-033 Leaky with LEAK_SHIFT=3: inputs -16, -1, 40 -> outputs -2, -1, 40.
REQ-034 Clipped with clip_val=100: inputs 150, 100, 50, -7 -> outputs 100, 100, 50, 0; clip_val=-1 -> all outputs 0.
REQ-035 start held high continuously -> runs are back-to-back with one idle cycle between them; a start pulse mid-run leaves the beat sequence unchanged.
REQ-036 With ACT_SAT_COUNT_EN, ReLU on a vector with 37 negatives -> sat_count=37 at done.
